// File: rtl/lsu_dtag_perr_ctl.sv
// lsu_dtag_perr_ctl: dtag parity error logger and set invalidator; define LSU_DTAG_PERR_INJ_EN for error injection ports
module lsu_dtag_perr_ctl #(
  parameter int IDX_W = 7,
  parameter int CNT_W = 8
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             tag_chk_vld_g,
  input  logic [IDX_W-1:0] tag_chk_idx_g,
  input  logic [1:0]       tag_chk_tid_g,
  input  logic [3:0]       lsu_rd_dtag_parity_g,
  input  logic [3:0]       dva_vld_g,
  input  logic             perr_inv_gnt,
  input  logic             perr_cnt_clr,
`ifdef LSU_DTAG_PERR_INJ_EN
  input  logic             perr_inj_en,
  input  logic [3:0]       perr_inj_way,
`endif
  output logic             perr_inv_req,
  output logic [IDX_W-1:0] perr_inv_idx,
  output logic             perr_busy,
  output logic             perr_err_vld,
  output logic [3:0]       perr_err_way,
  output logic [1:0]       perr_err_tid,
  output logic [CNT_W-1:0] perr_err_cnt,
  output logic             perr_ovf
);
  typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;
  state_t state, state_nxt;
  logic settle_cnt;
  logic [3:0] par, way;
  logic det, acc;
`ifdef LSU_DTAG_PERR_INJ_EN
  assign par = lsu_rd_dtag_parity_g ^ (perr_inj_way & {4{perr_inj_en}});
`else
  assign par = lsu_rd_dtag_parity_g;
`endif
  assign way = par & dva_vld_g;
  assign det = tag_chk_vld_g & |way;
  assign acc = det & (state == IDLE);
  assign perr_busy = state != IDLE;
  assign perr_inv_req = state == REQ;
  always_comb
    state_nxt = state == IDLE ? (det ? REQ : IDLE) :
                state == REQ  ? (perr_inv_gnt ? SETTLE : REQ) :
                settle_cnt    ? IDLE : SETTLE;
  always_ff @(posedge rclk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge rclk) begin
    if (rst) begin
      settle_cnt   <= 1'b0;
      perr_err_vld <= 1'b0;
      perr_inv_idx <= '0;
      perr_err_way <= '0;
      perr_err_tid <= '0;
    end else begin
      settle_cnt   <= (state == SETTLE) & ~settle_cnt;
      perr_err_vld <= acc;
      if (acc) begin
        perr_inv_idx <= tag_chk_idx_g;
        perr_err_way <= way;
        perr_err_tid <= tag_chk_tid_g;
      end
    end
  end
  always_ff @(posedge rclk) begin
    if (rst || perr_cnt_clr) begin
      perr_err_cnt <= '0;
      perr_ovf     <= 1'b0;
    end else begin
      if (acc && !(&perr_err_cnt)) perr_err_cnt <= perr_err_cnt + CNT_W'(1);
      if (det && perr_busy) perr_ovf <= 1'b1;
    end
  end
endmodule
